rot_issue_stage: RTL and testbench
==================================

# rot_issue_stage

Issue stage that sits directly upstream of the 4-bit combinational rotator (`barrel_shifter`). It buffers rotate requests in a small FIFO and converts a direction/amount pair into the rotator's 2-bit select. It drives the rotator's operand and select from registers and captures the rotator's result into an output register with a valid/ready handshake. The rotator's combinational path therefore always sits between two registers of this block.

## Interface
Parameters:
- `FIFO_DEPTH`, default 2: input request FIFO depth; power of two, legal range 2..8.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  request can be accepted; equals !fifo_full.
- `in_data`  in  4  word to rotate.
- `in_amt`  in  3  rotate amount; only `in_amt[1:0]` is used (rotation is mod 4).
- `in_dir`  in  1  0 = rotate right, 1 = rotate left.
- `bs_w`  out  4  registered operand to the rotator's `w`.
- `bs_s`  out  2  registered select to the rotator's `s`.
- `bs_y`  in  4  rotator result; the rotator computes `y[i] = w[(i+s) mod 4]`, which is a rotate right by `s`.
- `out_valid`  out  1  result register holds a valid result.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  4  registered rotate result.
- `op_count`  out  16  completed-result counter; present only with `ROT_STATS_EN`.

## Operation
- **Push:** when `in_valid && in_ready`, the tuple {`in_data`, `in_amt[1:0]`, `in_dir`} is written to the FIFO tail.
- **Select conversion at pop:**
  - right: `s = amt[1:0]`.
  - left: `s = (4 - amt[1:0]) mod 4`. For example, left 1 gives s=3, and left 0 gives s=0.
- **Stage A (issue register):** holds `bs_w`, `bs_s`, and a flag `a_valid`. While `a_valid` is 0, `bs_w` and `bs_s` hold their last values.
- **Stage B (result register):** holds `out_data` and `out_valid`.
- **Advance rules**, evaluated in the same cycle:
  - `b_take = a_valid && (!out_valid || out_ready)`.
  - `a_take = !fifo_empty && (!a_valid || b_take)`.
- **On `b_take`:** `out_data <= bs_y` and `out_valid <= 1`.
- **On `out_valid && out_ready && !b_take`:** `out_valid <= 0`.
- **On `a_take`:** stage A loads the FIFO head, `a_valid <= 1`, and the FIFO pops. Otherwise, if `b_take`, `a_valid <= 0`.
- **No bypass:** a request always passes through the FIFO, stage A, and stage B in that order.
- **Ordering:** results are returned strictly in request order.
- **`in_ready` is independent of same-cycle pops:** it is not raised by a pop happening in the same cycle. When full, a push is refused even if a pop occurs that cycle.
- **FIFO pointers:** log2(FIFO_DEPTH)+1 bits wide; wrap-around is natural; full/empty are decided by comparing the MSB plus the equality of the lower bits.
- **Simultaneous push and pop:** when the FIFO is not full, both occur and the occupancy is unchanged.

## Timing
- **Reset values:**
  - `in_ready` = 1, `bs_w` = 0, `bs_s` = 0, `out_valid` = 0, `out_data` = 0, `op_count` = 0.
  - FIFO is empty and `a_valid` = 0.
- **Latency:** a request accepted at edge t appears in stage A after edge t+1. `out_valid` rises after edge t+2, with no stall.
- **Throughput:** one result per cycle while `out_ready` stays high.
- **Capacity:** with `out_ready` held low, FIFO_DEPTH+2 requests are accepted before `in_ready` falls.
- **Output stability:** `out_data` stays stable while `out_valid && !out_ready`.
- **Reset mid-operation:** asserting `rst` discards all buffered and in-flight requests immediately and asynchronously, and all outputs return to their reset values.

## Configuration
- **`ROT_STATS_EN` defined:**
  - `op_count` is present.
  - It increments by 1 on every `out_valid && out_ready` cycle.
  - It wraps from 0xFFFF to 0 and resets to 0.
- **`ROT_STATS_EN` undefined:** the `op_count` port and its logic are absent, and the remaining behaviour is identical.

## Test plan
The bench connects the rotator model `y[i] = w[(i+s) mod 4]` between `bs_w`/`bs_s` and `bs_y`. `FIFO_DEPTH` = 2 unless a scenario states otherwise.
- Right rotate: data 4'b0001, amt 1, dir 0 -> `bs_s` = 1, and `out_data` = 4'b1000 two cycles after acceptance.
- Left rotate and amount wrap: (4'b0001, amt 1, left) -> `bs_s` = 3, `out_data` = 4'b0010. Then (4'b0110, amt 5, right) -> `out_data` = 4'b0011, because `in_amt[2]` is ignored.
- Back-pressure: hold `out_ready` = 0 and offer 5 requests (0x1, 0x2, 0x4, 0x8, 0x3, all right rotate by amt 0) -> exactly 4 are accepted and `in_ready` = 0. Then raise `out_ready` -> results come out 0x1, 0x2, 0x4, 0x8 in order, and the 5th request is accepted after the first pop.
- Streaming: 20 back-to-back random requests with `out_ready` = 1 -> 20 correct results on consecutive cycles after the 2-cycle latency, with no bubbles.
- Reset mid-operation: with 3 requests in flight, pulse `rst` between clock edges -> `out_valid` = 0, `in_ready` = 1, `bs_w`/`bs_s` = 0 immediately, and no stale result is produced afterwards.
- With `ROT_STATS_EN` defined: after 10 completed handshakes `op_count` = 10. Preload near the wrap point by running 65536 handshakes -> `op_count` = 0.

Source files
------------

// File: rtl/rot_issue_if.sv
// Request, rotator and result bus of rot_issue_stage.
// master = issue stage side, slave = producer/rotator/consumer side.
interface rot_issue_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [2:0] in_amt;
  logic       in_dir;
  logic [3:0] bs_w;
  logic [1:0] bs_s;
  logic [3:0] bs_y;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;

  modport master (
    input  in_valid, in_data, in_amt, in_dir, bs_y, out_ready,
    output in_ready, bs_w, bs_s, out_valid, out_data
  );

  modport slave (
    output in_valid, in_data, in_amt, in_dir, bs_y, out_ready,
    input  in_ready, bs_w, bs_s, out_valid, out_data
  );
endinterface

// File: rtl/rot_issue_stage.sv
// Issue stage for the 4-bit rotator: request FIFO -> issue register (bs_w/bs_s) -> result register.
// Optional completed-result counter op_count is built when ROT_STATS_EN is defined.
module rot_issue_stage #(
  parameter int FIFO_DEPTH = 2
) (
  input logic         clk,
  input logic         rst,
  rot_issue_if.master bus
`ifdef ROT_STATS_EN
  ,
  output logic [15:0] op_count
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [3:0] data;
    logic [1:0] amt;
    logic       dir;
  } req_t;

  req_t        fifo_mem_r [FIFO_DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic        a_valid_r;
  logic [3:0]  bs_w_r;
  logic [1:0]  bs_s_r;
  logic        out_valid_r;
  logic [3:0]  out_data_r;

  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic        push_s;
  logic        a_take_s;
  logic        b_take_s;
  req_t        head_s;
  logic        amt_unused_s;

  // The rotator only rotates right, so a left rotate by n becomes right by (4-n) mod 4.
  function automatic logic [1:0] sel_of(input logic [1:0] amt, input logic dir);
    logic [1:0] s;
    if (dir) begin
      s = 2'd0 - amt;
    end else begin
      s = amt;
    end
    return s;
  endfunction

  assign amt_unused_s = bus.in_amt[2];

  // FIFO status and the stage advance decisions.
  always_comb begin
    fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    fifo_full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    push_s       = bus.in_valid && !fifo_full_s;
    b_take_s     = a_valid_r && (!out_valid_r || bus.out_ready);
    a_take_s     = !fifo_empty_s && (!a_valid_r || b_take_s);
    head_s       = fifo_mem_r[rd_ptr_r[AW-1:0]];
  end

  // FIFO storage; contents are meaningless until the pointers say otherwise.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r[AW-1:0]] <= '{data: bus.in_data, amt: bus.in_amt[1:0], dir: bus.in_dir};
    end
  end

  // FIFO pointers, issue register and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      a_valid_r   <= 1'b0;
      bs_w_r      <= 4'd0;
      bs_s_r      <= 2'd0;
      out_valid_r <= 1'b0;
      out_data_r  <= 4'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (a_take_s) begin
        rd_ptr_r  <= rd_ptr_r + (AW+1)'(1);
        a_valid_r <= 1'b1;
        bs_w_r    <= head_s.data;
        bs_s_r    <= sel_of(head_s.amt, head_s.dir);
      end else if (b_take_s) begin
        a_valid_r <= 1'b0;
      end
      // bs_y is the rotator's view of the registered bs_w/bs_s.
      if (b_take_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= bus.bs_y;
      end else if (out_valid_r && bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = !fifo_full_s;
  assign bus.bs_w      = bs_w_r;
  assign bus.bs_s      = bs_s_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;

`ifdef ROT_STATS_EN
  logic [15:0] op_count_r;

  // Completed-result counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_r <= 16'd0;
    end else if (out_valid_r && bus.out_ready) begin
      op_count_r <= op_count_r + 16'd1;
    end
  end

  assign op_count = op_count_r;
`endif
endmodule

// File: tb/tb_rot_issue_stage.sv
// Directed self-checking bench for rot_issue_stage with a behavioural rotator on bs_w/bs_s -> bs_y.
module tb_rot_issue_stage;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [3:0] bp_data [5];
  rot_issue_if bif ();
`ifdef ROT_STATS_EN
  logic [15:0] op_count;
`endif

  rot_issue_stage #(.FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
`ifdef ROT_STATS_EN
    ,
    .op_count (op_count)
`endif
  );

  function automatic logic [3:0] rot_model(input logic [3:0] w, input logic [1:0] s);
    logic [3:0] y;
    for (int i = 0; i < 4; i++) y[i] = w[(i + int'(s)) % 4];
    return y;
  endfunction

  function automatic logic [1:0] exp_sel(input logic [2:0] amt, input logic dir);
    int a;
    a = int'(amt) % 4;
    return dir ? 2'((4 - a) % 4) : 2'(a);
  endfunction

  assign bif.bs_y = rot_model(bif.bs_w, bif.bs_s);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_check(input string tag, input logic [3:0] data, input logic [2:0] amt,
                            input logic dir, input logic [1:0] exp_s, input logic [3:0] exp_y);
    bif.in_valid = 1'b1;
    bif.in_data  = data;
    bif.in_amt   = amt;
    bif.in_dir   = dir;
    check({tag, "_ready"}, 16'(bif.in_ready), 16'd1);
    tick();
    bif.in_valid = 1'b0;
    check({tag, "_v0"}, 16'(bif.out_valid), 16'd0);
    tick();
    check({tag, "_bs_s"}, 16'(bif.bs_s), 16'(exp_s));
    check({tag, "_bs_w"}, 16'(bif.bs_w), 16'(data));
    check({tag, "_v1"}, 16'(bif.out_valid), 16'd0);
    tick();
    check({tag, "_v2"}, 16'(bif.out_valid), 16'd1);
    check({tag, "_data"}, 16'(bif.out_data), 16'(exp_y));
    tick();
    check({tag, "_v3"}, 16'(bif.out_valid), 16'd0);
  endtask

  task automatic stream(input string tag, input int n);
    logic [3:0] exp_y [32];
    for (int c = 0; c < n + 2; c++) begin
      if (c < n) begin
        bif.in_valid = 1'b1;
        bif.in_data  = 4'($urandom_range(0, 15));
        bif.in_amt   = 3'($urandom_range(0, 7));
        bif.in_dir   = 1'($urandom_range(0, 1));
        exp_y[c]     = rot_model(bif.in_data, exp_sel(bif.in_amt, bif.in_dir));
        check({tag, "_ready"}, 16'(bif.in_ready), 16'd1);
      end else begin
        bif.in_valid = 1'b0;
      end
      tick();
      if (c >= 2) begin
        check({tag, "_valid"}, 16'(bif.out_valid), 16'd1);
        check({tag, "_data"}, 16'(bif.out_data), 16'(exp_y[c-2]));
      end
    end
    tick();
    check({tag, "_drain"}, 16'(bif.out_valid), 16'd0);
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    bp_data       = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3};
    clk           = 1'b0;
    rst           = 1'b1;
    bif.in_valid  = 1'b0;
    bif.in_data   = 4'd0;
    bif.in_amt    = 3'd0;
    bif.in_dir    = 1'b0;
    bif.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", 16'(bif.in_ready), 16'd1);
    check("rst_bs_w", 16'(bif.bs_w), 16'd0);
    check("rst_bs_s", 16'(bif.bs_s), 16'd0);
    check("rst_out_valid", 16'(bif.out_valid), 16'd0);
    check("rst_out_data", 16'(bif.out_data), 16'd0);
`ifdef ROT_STATS_EN
    check("rst_op_count", op_count, 16'd0);
`endif

    send_check("right1", 4'b0001, 3'd1, 1'b0, 2'd1, 4'b1000);
    send_check("left1", 4'b0001, 3'd1, 1'b1, 2'd3, 4'b0010);
    send_check("amt5", 4'b0110, 3'd5, 1'b0, 2'd1, 4'b0011);
    send_check("left0", 4'b1011, 3'd0, 1'b1, 2'd0, 4'b1011);
    send_check("left2", 4'b1100, 3'd2, 1'b1, 2'd2, 4'b0011);

    // back-pressure: four accepted, fifth refused until the first pop
    bif.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bif.in_valid = 1'b1;
      bif.in_data  = bp_data[i];
      bif.in_amt   = 3'd0;
      bif.in_dir   = 1'b0;
      check("bp_accept", 16'(bif.in_ready), 16'd1);
      tick();
    end
    bif.in_data = bp_data[4];
    check("bp_full", 16'(bif.in_ready), 16'd0);
    check("bp_valid", 16'(bif.out_valid), 16'd1);
    check("bp_r0", 16'(bif.out_data), 16'h1);
    tick();
    check("bp_full_hold", 16'(bif.in_ready), 16'd0);
    check("bp_stable", 16'(bif.out_data), 16'h1);
    bif.out_ready = 1'b1;
    tick();
    check("bp_r1", 16'(bif.out_data), 16'h2);
    check("bp_ready_again", 16'(bif.in_ready), 16'd1);
    tick();
    bif.in_valid = 1'b0;
    check("bp_r2", 16'(bif.out_data), 16'h4);
    tick();
    check("bp_r3", 16'(bif.out_data), 16'h8);
    tick();
    check("bp_r4", 16'(bif.out_data), 16'h3);
    check("bp_r4_valid", 16'(bif.out_valid), 16'd1);
    tick();
    check("bp_empty", 16'(bif.out_valid), 16'd0);

    stream("stream", 20);

    // asynchronous reset with three requests in flight
    bif.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bif.in_valid = 1'b1;
      bif.in_data  = 4'hA + 4'(i);
      bif.in_amt   = 3'd1;
      bif.in_dir   = 1'b0;
      tick();
    end
    bif.in_valid = 1'b0;
    check("mid_inflight", 16'(bif.out_valid), 16'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_out_valid", 16'(bif.out_valid), 16'd0);
    check("mid_in_ready", 16'(bif.in_ready), 16'd1);
    check("mid_bs_w", 16'(bif.bs_w), 16'd0);
    check("mid_bs_s", 16'(bif.bs_s), 16'd0);
    check("mid_out_data", 16'(bif.out_data), 16'd0);
    #1;
    rst = 1'b0;
    bif.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_no_stale", 16'(bif.out_valid), 16'd0);
    end

`ifdef ROT_STATS_EN
    check("stats_after_rst", op_count, 16'd0);
    stream("stats10", 10);
    check("stats_10", op_count, 16'd10);
    bif.in_valid = 1'b1;
    bif.in_data  = 4'h5;
    bif.in_amt   = 3'd2;
    bif.in_dir   = 1'b1;
    repeat (65526) tick();
    bif.in_valid = 1'b0;
    repeat (4) tick();
    check("stats_wrap", op_count, 16'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
